// File: rtl/mac4x4_acc.sv
// Streaming 4x4 multiply-accumulate engine: sums a programmable number of a*b products
// through a one-entry product stage, with a sticky carry-out flag and a valid/ready result.

module dadda4x4_3_2 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] pp [0:3];
    logic s1a, c1a, s1b, c1b;
    logic s2, c2, s3, c3, s4, c4, s5, c5;
    logic [7:0] row_x, row_y;

    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign pp[i] = b & {4{a[i]}};
    end

    // Stage 1: squeeze the weight-3 and weight-4 columns down to height 3
    assign s1a = pp[0][3] ^ pp[1][2];
    assign c1a = pp[0][3] & pp[1][2];
    assign s1b = pp[1][3] ^ pp[2][2];
    assign c1b = pp[1][3] & pp[2][2];

    // Stage 2: every column down to height 2 using one half adder and three full adders
    assign s2 = pp[0][2] ^ pp[1][1];
    assign c2 = pp[0][2] & pp[1][1];
    assign s3 = pp[2][1] ^ pp[3][0] ^ s1a;
    assign c3 = (pp[2][1] & pp[3][0]) | (s1a & (pp[2][1] ^ pp[3][0]));
    assign s4 = pp[3][1] ^ c1a ^ s1b;
    assign c4 = (pp[3][1] & c1a) | (s1b & (pp[3][1] ^ c1a));
    assign s5 = pp[2][3] ^ pp[3][2] ^ c1b;
    assign c5 = (pp[2][3] & pp[3][2]) | (c1b & (pp[2][3] ^ pp[3][2]));

    assign row_x = {1'b0, pp[3][3], s5, s4, s3, pp[2][0], pp[0][1], pp[0][0]};
    assign row_y = {1'b0, c5, c4, c3, c2, s2, pp[1][0], 1'b0};
    assign p     = row_x + row_y;
endmodule

module mac4x4_acc #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             overflow,
    output logic             busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   target;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W:0]   len_ext;
    logic [7:0]       prod;
    logic [7:0]       prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             ovf_q;
    logic             out_valid_q;
    logic             xfer;

    dadda4x4_3_2 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign xfer    = in_valid && (state == ACCUM);
    assign cnt_inc = cnt + {{LEN_W{1'b0}}, 1'b1};
    // A zero length field stands for the full 2^LEN_W terms
    assign len_ext = (len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    assign acc_sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_q};

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = acc;
    assign overflow  = ovf_q;

    // Product stage, accumulator and job-sequencing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            target      <= '0;
            prod_q      <= 8'd0;
            prod_v      <= 1'b0;
            acc         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            prod_v <= xfer;
            if (xfer) begin
                prod_q <= prod;
            end
            if (prod_v) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    ovf_q <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        ovf_q  <= 1'b0;
                        cnt    <= '0;
                        target <= len_ext;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == target) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle lets the final sum settle before it is offered
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac4x4_acc.sv
// Bench for mac4x4_acc: a 16-bit and an 8-bit accumulator run the same stimulus in lockstep,
// checked against totals queued by the bench when the operand pairs are driven.

module tb_mac4x4_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] sum16;
    logic        in_ready8, out_valid8, ovf8, busy8;
    logic [7:0]  sum8;

    int tests = 0;
    int fails = 0;
    int sb[$];

    mac4x4_acc #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready16), .a(a), .b(b), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .overflow(ovf16), .busy(busy16)
    );

    mac4x4_acc #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready8), .a(a), .b(b), .out_valid(out_valid8),
        .out_ready(out_ready), .sum(sum8), .overflow(ovf8), .busy(busy8)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [3:0] x, input logic [3:0] y, input int gap);
        int n = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!in_ready16 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (!in_ready16) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready16);
        end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid16 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (!out_valid16) begin
            fails++;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid16);
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready16, out_valid16, busy16, ovf16, sum16} !== 20'd0) begin
            fails++;
            $display("FAIL reset16: rdy/vld/busy/ovf/sum=%0b/%0b/%0b/%0b/%0d required all 0",
                     in_ready16, out_valid16, busy16, ovf16, sum16);
        end
        tests++;
        if ({in_ready8, out_valid8, busy8, ovf8, sum8} !== 12'd0) begin
            fails++;
            $display("FAIL reset8: rdy/vld/busy/ovf/sum=%0b/%0b/%0b/%0b/%0d required all 0",
                     in_ready8, out_valid8, busy8, ovf8, sum8);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int exp;
        start_job(4'd1);
        sb.push_back(225);
        send_pair(4'd15, 4'd15, 0);
        tests++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0) begin
            fails++;
            $display("FAIL lat_edge0: in_ready=%0b out_valid=%0b required 0/0", in_ready16, out_valid16);
        end
        tick();
        tests++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b1) begin
            fails++;
            $display("FAIL lat_edge1: out_valid=%0b busy=%0b required 0/1", out_valid16, busy16);
        end
        tick();
        tests++;
        if (out_valid16 !== 1'b1 || out_valid8 !== 1'b1) begin
            fails++;
            $display("FAIL lat_edge2: out_valid16=%0b out_valid8=%0b required 1/1", out_valid16, out_valid8);
        end
        exp = sb.pop_front();
        tests++;
        if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
            fails++;
            $display("FAIL lat_sum16: sum=%0d ovf=%0b required %0d/%0b", sum16, ovf16, exp[15:0], exp >= 65536);
        end
        tests++;
        if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
            fails++;
            $display("FAIL lat_sum8: sum=%0d ovf=%0b required %0d/%0b", sum8, ovf8, exp[7:0], exp >= 256);
        end
        ack();
        tests++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || sum16 !== 16'd225) begin
            fails++;
            $display("FAIL lat_idle: out_valid=%0b busy=%0b sum=%0d required 0/0/225", out_valid16, busy16, sum16);
        end
    endtask

    task automatic test_gapped();
        int exp;
        start_job(4'd4);
        sb.push_back(3*5 + 2*7 + 15*15 + 0*9);
        send_pair(4'd3, 4'd5, 2);
        send_pair(4'd2, 4'd7, 2);
        send_pair(4'd15, 4'd15, 2);
        send_pair(4'd0, 4'd9, 2);
        wait_valid();
        exp = sb.pop_front();
        tests++;
        if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
            fails++;
            $display("FAIL gap_sum16: sum=%0d ovf=%0b required %0d/%0b", sum16, ovf16, exp[15:0], exp >= 65536);
        end
        tests++;
        if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
            fails++;
            $display("FAIL gap_sum8: sum=%0d ovf=%0b required %0d/%0b", sum8, ovf8, exp[7:0], exp >= 256);
        end
        ack();
    endtask

    task automatic test_full_length();
        int exp;
        start_job(4'd0);
        sb.push_back(16 * 225);
        for (int i = 0; i < 16; i++) send_pair(4'd15, 4'd15, 0);
        a = 4'd15;
        b = 4'd15;
        in_valid = 1'b1;
        tests++;
        if (in_ready16 !== 1'b0 || in_ready8 !== 1'b0) begin
            fails++;
            $display("FAIL full_17th: in_ready16=%0b in_ready8=%0b required 0/0", in_ready16, in_ready8);
        end
        repeat (3) tick();
        in_valid = 1'b0;
        wait_valid();
        exp = sb.pop_front();
        tests++;
        if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
            fails++;
            $display("FAIL full_sum16: sum=%0d ovf=%0b required %0d/%0b", sum16, ovf16, exp[15:0], exp >= 65536);
        end
        tests++;
        if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
            fails++;
            $display("FAIL full_sum8: sum=%0d ovf=%0b required %0d/%0b", sum8, ovf8, exp[7:0], exp >= 256);
        end
        ack();
    endtask

    task automatic test_overflow_clear();
        int exp;
        start_job(4'd2);
        sb.push_back(450);
        send_pair(4'd15, 4'd15, 0);
        send_pair(4'd15, 4'd15, 0);
        wait_valid();
        exp = sb.pop_front();
        tests++;
        if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
            fails++;
            $display("FAIL ovf_sum8: sum=%0d ovf=%0b required %0d/%0b", sum8, ovf8, exp[7:0], exp >= 256);
        end
        tests++;
        if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
            fails++;
            $display("FAIL ovf_sum16: sum=%0d ovf=%0b required %0d/%0b", sum16, ovf16, exp[15:0], exp >= 65536);
        end
        ack();
        start_job(4'd1);
        sb.push_back(1);
        send_pair(4'd1, 4'd1, 0);
        wait_valid();
        exp = sb.pop_front();
        tests++;
        if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
            fails++;
            $display("FAIL ovf_clear8: sum=%0d ovf=%0b required %0d/%0b", sum8, ovf8, exp[7:0], exp >= 256);
        end
        ack();
    endtask

    task automatic test_backpressure();
        int exp;
        start_job(4'd1);
        sb.push_back(6);
        send_pair(4'd2, 4'd3, 0);
        wait_valid();
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 4'd5;
            tick();
            tests++;
            if (out_valid16 !== 1'b1 || sum16 !== exp[15:0] || ovf16 !== 1'b0 || sum8 !== exp[7:0]) begin
                fails++;
                $display("FAIL hold_%0d: out_valid=%0b sum16=%0d ovf=%0b sum8=%0d required 1/%0d/0/%0d",
                         i, out_valid16, sum16, ovf16, sum8, exp[15:0], exp[7:0]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        tests++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: out_valid=%0b busy16=%0b busy8=%0b required 0/0/0",
                     out_valid16, busy16, busy8);
        end
        tick();
        tests++;
        if (busy16 !== 1'b0 || sum16 !== exp[15:0]) begin
            fails++;
            $display("FAIL hold_idle: busy=%0b sum=%0d required 0/%0d", busy16, sum16, exp[15:0]);
        end
    endtask

    task automatic test_mid_reset();
        int exp;
        start_job(4'd4);
        send_pair(4'd5, 4'd5, 0);
        send_pair(4'd6, 4'd6, 0);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready16, out_valid16, busy16, ovf16, sum16} !== 20'd0) begin
            fails++;
            $display("FAIL midrst16: rdy/vld/busy/ovf/sum=%0b/%0b/%0b/%0b/%0d required all 0",
                     in_ready16, out_valid16, busy16, ovf16, sum16);
        end
        tests++;
        if ({in_ready8, out_valid8, busy8, ovf8, sum8} !== 12'd0) begin
            fails++;
            $display("FAIL midrst8: rdy/vld/busy/ovf/sum=%0b/%0b/%0b/%0b/%0d required all 0",
                     in_ready8, out_valid8, busy8, ovf8, sum8);
        end
        tick();
        rst = 1'b0;
        start_job(4'd1);
        tests++;
        if (busy16 !== 1'b1 || in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            fails++;
            $display("FAIL midrst_start: busy=%0b in_ready=%0b out_valid=%0b required 1/1/0",
                     busy16, in_ready16, out_valid16);
        end
        sb.push_back(16);
        send_pair(4'd4, 4'd4, 0);
        wait_valid();
        exp = sb.pop_front();
        tests++;
        if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
            fails++;
            $display("FAIL midrst_sum16: sum=%0d ovf=%0b required %0d/%0b", sum16, ovf16, exp[15:0], exp >= 65536);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int exp;
        int total;
        logic [3:0] l, x, y;
        for (int j = 0; j < 3; j++) begin
            l = 4'($urandom_range(1, 15));
            start_job(l);
            total = 0;
            for (int i = 0; i < int'(l); i++) begin
                x = 4'($urandom_range(0, 15));
                y = 4'($urandom_range(0, 15));
                total += int'(x) * int'(y);
                send_pair(x, y, int'($urandom_range(0, 1)));
            end
            sb.push_back(total);
            wait_valid();
            exp = sb.pop_front();
            tests++;
            if (sum16 !== exp[15:0] || ovf16 !== (exp >= 65536)) begin
                fails++;
                $display("FAIL b2b_sum16_%0d: sum=%0d ovf=%0b required %0d/%0b", j, sum16, ovf16, exp[15:0], exp >= 65536);
            end
            tests++;
            if (sum8 !== exp[7:0] || ovf8 !== (exp >= 256)) begin
                fails++;
                $display("FAIL b2b_sum8_%0d: sum=%0d ovf=%0b required %0d/%0b", j, sum8, ovf8, exp[7:0], exp >= 256);
            end
            ack();
        end
    endtask

    initial begin
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        test_reset();
        test_latency();
        test_gapped();
        test_full_length();
        test_overflow_clear();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mac4x4_acc.md
MAC4X4_ACC -- requirements
Module: mac4x4_acc

Interface
REQ-001 Parameter: ACC_W, 16, accumulator/result width (legal range 8..24).
REQ-002 Parameter: LEN_W, 4, term-count field width; 0 encodes 2^LEN_W terms.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: start  input  1  begin a new accumulation; honoured only in IDLE.
REQ-006 Port: len  input  LEN_W  number of products to sum; sampled on an honoured start.
REQ-007 Port: in_valid  input  1  operand pair a/b is valid.
REQ-008 Port: in_ready  output  1  block accepts an operand pair this cycle.
REQ-009 Port: a  input  4  unsigned multiplicand.
REQ-010 Port: b  input  4  unsigned multiplier.
REQ-011 Port: out_valid  output  1  sum/overflow are valid.
REQ-012 Port: out_ready  input  1  consumer takes the result.
REQ-013 Port: sum  output  ACC_W  accumulated sum of products.
REQ-014 Port: overflow  output  1  sticky carry-out of the accumulator for the current job.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 The 8-bit product SHALL come from an internal instance of dadda4x4_3_2 driven by a and b; no behavioural multiply.
REQ-017 FSM states SHALL be IDLE, ACCUM, DRAIN, DONE; encoding is free.
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 -> clear accumulator, overflow, term counter; latch len; go to ACCUM.
REQ-019 ACCUM: in_ready=1; a transfer occurs on an edge where in_valid && in_ready; gaps in in_valid SHALL stall without effect.
REQ-020 On each transfer the product SHALL be registered into a one-entry product stage (prod_q, prod_v=1); at the next edge prod_q SHALL be zero-extended and added to the accumulator.
REQ-021 The term counter SHALL increment per transfer; on the transfer that reaches the latched count (0 means 2^LEN_W), state SHALL move to DRAIN and in_ready SHALL be 0 from the next cycle.
REQ-022 DRAIN: one cycle; the last product is added; then go to DONE.
REQ-023 Latency: out_valid SHALL first be high in the cycle following the second rising edge after the last transfer edge.
REQ-024 Accumulator SHALL wrap modulo 2^ACC_W; any carry-out SHALL set overflow, which stays set until the next honoured start or reset.
REQ-025 DONE: out_valid=1; sum and overflow SHALL hold stable while out_ready=0; on out_valid && out_ready, go to IDLE with out_valid=0 next cycle.
REQ-026 start asserted in ACCUM, DRAIN or DONE (including the DONE handshake cycle) SHALL be ignored; a and b SHALL be ignored whenever in_ready=0.
REQ-027 After returning to IDLE, sum SHALL keep its last value until the next honoured start clears it.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, with in_ready=0, out_valid=0, busy=0, sum=0, overflow=0, prod_v=0, term counter=0, independent of clk.
REQ-029 rst asserted mid-ACCUM, DRAIN or DONE SHALL discard the job; no partial result SHALL be presented after release.
REQ-030 First start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-031 len=1, (a,b)=(15,15) -> sum=225, overflow=0, out_valid exactly per REQ-023.
REQ-032 len=4, pairs (3,5),(2,7),(15,15),(0,9) with in_valid gapped 2 cycles between pairs -> sum=254, overflow=0.
REQ-033 len=0, sixteen pairs (15,15) -> sum=3600, overflow=0; 17th pair presented is not accepted (in_ready=0).
REQ-034 ACC_W=8, len=2, pairs (15,15),(15,15) -> sum=194, overflow=1; next job len=1 (1,1) -> sum=1, overflow=0.
REQ-035 DONE with out_ready=0 for 5 cycles and start pulsed meanwhile -> sum/overflow stable, start ignored, single handshake then IDLE.
REQ-036 rst pulsed mid-ACCUM after 2 of 4 terms -> all outputs zero immediately; fresh len=1 (4,4) job -> sum=16.
